// File: rtl/counter_cmd_sequencer.sv
// Command sequencer for a 4-bit up/down counter: buffers burst commands
// {dir, len, gap} in a small FIFO and replays each one as single-cycle en
// pulses with a stable up_dn, followed by a one-cycle done pulse.
module counter_cmd_sequencer #(
    parameter int LEN_W      = 4,
    parameter int GAP_W      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_dir,
    input  logic [LEN_W-1:0]              cmd_len,
    input  logic [GAP_W-1:0]              cmd_gap,
    output logic                          en,
    output logic                          up_dn,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int CMD_W = 1 + LEN_W + GAP_W;

    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    // FIFO storage and pointers; pointers wrap naturally (depth is a power of two)
    logic [CMD_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    // Sequencer state and working counters
    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [GAP_W-1:0] gap_cfg_q, gap_cfg_d;
    logic             up_dn_q, up_dn_d;
    logic             done_q, done_d;

    logic             push;
    logic             pop;
    logic [CMD_W-1:0] head;
    logic             head_dir;
    logic [LEN_W-1:0] head_len;
    logic [GAP_W-1:0] head_gap;

    // Ready depends only on the registered level, never on cmd_valid
    assign cmd_ready = (level_q < DEPTH_L);
    assign push      = cmd_valid & cmd_ready;
    // A command is taken only while idle; done cycles are idle, so a pop can overlap done
    assign pop       = (state_q == S_IDLE) && (level_q != '0);

    assign head      = fifo_mem_q[rd_ptr_q];
    assign head_dir  = head[CMD_W-1];
    assign head_len  = head[GAP_W +: LEN_W];
    assign head_gap  = head[GAP_W-1:0];

    assign en         = (state_q == S_STEP);
    assign up_dn      = up_dn_q;
    assign done       = done_q;
    assign busy       = (state_q != S_IDLE) | (level_q != '0);
    assign fifo_level = level_q;

    // FIFO pointer and occupancy next-state; push and pop together leave the level unchanged
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Burst FSM: IDLE pops and latches a command, STEP issues one en pulse, GAP waits gap_cfg cycles
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        gcnt_d    = gcnt_q;
        gap_cfg_d = gap_cfg_q;
        up_dn_d   = up_dn_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    up_dn_d   = head_dir;
                    rem_d     = head_len;
                    gap_cfg_d = head_gap;
                    gcnt_d    = '0;
                    if (head_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == LEN_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gap_cfg_q == '0) begin
                    state_d = S_STEP;
                end else begin
                    state_d = S_GAP;
                    gcnt_d  = gap_cfg_q;
                end
            end
            S_GAP: begin
                gcnt_d = gcnt_q - 1'b1;
                if (gcnt_q == GAP_W'(1)) begin
                    state_d = S_STEP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; reset flushes the FIFO and abandons any command in flight without done
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= S_IDLE;
            rem_q     <= '0;
            gcnt_q    <= '0;
            gap_cfg_q <= '0;
            up_dn_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            rem_q     <= rem_d;
            gcnt_q    <= gcnt_d;
            gap_cfg_q <= gap_cfg_d;
            up_dn_q   <= up_dn_d;
            done_q    <= done_d;
        end
    end

    // FIFO payload storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_dir, cmd_len, cmd_gap};
        end
    end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer: directed bursts plus random traffic,
// scored against a schedule-level reference model and a downstream counter.
module tb_counter_cmd_sequencer;

    localparam int LEN_W      = 4;
    localparam int GAP_W      = 2;
    localparam int FIFO_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b1;
    logic             cmd_ready;
    logic             cmd_dir = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [GAP_W-1:0] cmd_gap = '0;
    logic             en;
    logic             up_dn;
    logic             busy;
    logic             done;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    counter_cmd_sequencer #(
        .LEN_W(LEN_W),
        .GAP_W(GAP_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_len(cmd_len),
        .cmd_gap(cmd_gap),
        .en(en),
        .up_dn(up_dn),
        .busy(busy),
        .done(done),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream 4-bit up/down counter driven by the DUT outputs
    logic [3:0] q_tb = 4'd0;
    always @(posedge clk) begin
        if (rst) q_tb <= 4'd0;
        else if (en) q_tb <= up_dn ? q_tb + 4'd1 : q_tb - 4'd1;
    end

    // Reference model: each accepted command becomes a timed schedule
    typedef struct {
        int acc;
        int pop;
        int fin;
        bit dir;
    } cmd_t;

    cmd_t       cmds[$];
    int         en_cyc[$];
    bit         en_dir[$];
    int         done_cyc[$];
    int         last_done = -100;
    logic [3:0] q_exp = 4'd0;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_clear();
        cmds.delete();
        en_cyc.delete();
        en_dir.delete();
        done_cyc.delete();
        last_done = -100;
        q_exp = 4'd0;
    endfunction

    // A command accepted in cycle c starts at c+2, or one cycle after the previous done
    function automatic void model_accept(int c, bit d, int len, int gap);
        int   s;
        int   fin;
        cmd_t e;
        s   = (c + 2 > last_done + 1) ? c + 2 : last_done + 1;
        fin = (len == 0) ? s : s + (len - 1) * (gap + 1) + 1;
        for (int k = 0; k < len; k++) begin
            en_cyc.push_back(s + k * (gap + 1));
            en_dir.push_back(d);
        end
        done_cyc.push_back(fin);
        last_done = fin;
        e.acc = c;
        e.pop = s - 1;
        e.fin = fin;
        e.dir = d;
        cmds.push_back(e);
        q_exp = d ? q_exp + 4'(len) : q_exp - 4'(len);
    endfunction

    // Monitor: compares every output each cycle against the model
    int m_lvl;
    bit m_bsy;
    bit m_up;
    bit m_en;
    bit m_done;
    always @(negedge clk) begin
        if (mon_on) begin
            m_lvl = 0;
            m_bsy = 1'b0;
            m_up  = 1'b1;
            foreach (cmds[i]) begin
                if (cmds[i].acc < cyc && cmds[i].pop >= cyc) m_lvl++;
                if (cmds[i].pop < cyc && cyc < cmds[i].fin) m_bsy = 1'b1;
                if (cmds[i].pop < cyc) m_up = cmds[i].dir;
            end
            if (m_lvl != 0) m_bsy = 1'b1;

            m_en = (en_cyc.size() > 0) && (en_cyc[0] == cyc);
            chk("en", int'(en), int'(m_en));
            if (m_en) begin
                chk("pulse_dir", int'(up_dn), int'(en_dir[0]));
                void'(en_cyc.pop_front());
                void'(en_dir.pop_front());
            end

            m_done = (done_cyc.size() > 0) && (done_cyc[0] == cyc);
            chk("done", int'(done), int'(m_done));
            if (m_done) void'(done_cyc.pop_front());

            chk("fifo_level", int'(fifo_level), m_lvl);
            chk("cmd_ready", int'(cmd_ready), int'(m_lvl < FIFO_DEPTH));
            chk("busy", int'(busy), int'(m_bsy));
            chk("up_dn", int'(up_dn), int'(m_up));
        end
    end

    task automatic drive(input bit v, input bit d, input int len, input int gap, output bit acc);
        @(posedge clk);
        #1;
        cmd_valid = v;
        cmd_dir   = d;
        cmd_len   = LEN_W'(len);
        cmd_gap   = GAP_W'(gap);
        acc = v && cmd_ready && !rst;
        if (acc) model_accept(cyc, d, len, gap);
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) drive(1'b0, 1'b0, 0, 0, a);
    endtask

    // Holds rst for n sampled edges with cmd_valid high; nothing may be accepted
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(5);
        repeat (n) begin
            @(posedge clk);
            #1;
            model_clear();
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        bit a;
        k = 0;
        while (done_cyc.size() != 0 && k < budget) begin
            drive(1'b0, 1'b0, 0, 0, a);
            k++;
        end
        chk("drain_pending", done_cyc.size(), 0);
        chk("counter_q", int'(q_tb), int'(q_exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         a;
        int         n_acc;
        logic [4:0] pat;

        // Reset held two edges with cmd_valid asserted
        @(posedge clk);
        #1;
        model_clear();
        mon_on = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        idle(2);

        // Basic burst: up by 3, back-to-back
        drive(1'b1, 1'b1, 3, 0, a);
        chk("basic_accept", int'(a), 1);
        drain(50);

        // Gap burst counting down from 0 (wraps to 15 then 14)
        do_reset(1);
        drive(1'b1, 1'b0, 2, 2, a);
        chk("gap_accept", int'(a), 1);
        drain(50);

        // Zero-length command
        drive(1'b1, 1'b1, 0, 3, a);
        chk("zero_accept", int'(a), 1);
        drain(50);

        // Back-pressure: cmd_valid held high with long commands
        n_acc = 0;
        pat   = 5'b10110;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, pat[n_acc % 5], 15, 0, a);
            if (a) n_acc++;
        end
        chk("bp_accepts", n_acc, 5);
        drain(400);

        // Reset during the 4th en of a 10-step burst, then a fresh burst
        drive(1'b1, 1'b1, 10, 0, a);
        idle(4);
        do_reset(1);
        idle(2);
        drive(1'b1, 1'b1, 3, 0, a);
        chk("post_reset_accept", int'(a), 1);
        drain(50);

        // Random traffic with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 3) == 0, 1'($urandom % 2),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), a);
            if (i == 200) do_reset(1 + int'($urandom % 2));
        end
        drain(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
